// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and widths for the ALU shift/rotate sequencer
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [2:0] {
        OP_ROL  = 3'b000,
        OP_ROR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_SHRA = 3'b100
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_SHRA;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shifter/rotator for one step of up to MAX_STEP bits
module shift_step
    import alu_pkg::*;
#(
    parameter int MAX_STEP = 8
) (
    input  logic [2:0]                i_op,
    input  logic [DATA_W-1:0]         i_value,
    input  logic [$clog2(MAX_STEP):0] i_amt,
    input  logic                      i_fill,
    output logic [DATA_W-1:0]         o_value
);

    logic [CNT_W-1:0]  w_back;
    logic [DATA_W-1:0] w_fill_mask;

    // Rotates merge the two directional shifts; amt=0 makes the back shift 32, i.e. zero.
    assign w_back      = 6'd32 - CNT_W'(i_amt);
    assign w_fill_mask = ~({DATA_W{1'b1}} >> i_amt);

    always_comb begin
        o_value = i_value;
        case (i_op)
            OP_ROL:  o_value = (i_value << i_amt) | (i_value >> w_back);
            OP_ROR:  o_value = (i_value >> i_amt) | (i_value << w_back);
            OP_SHL:  o_value = i_value << i_amt;
            OP_SHR:  o_value = i_value >> i_amt;
            OP_SHRA: o_value = (i_value >> i_amt) | (i_fill ? w_fill_mask : '0);
            default: o_value = i_value;
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// rtl/alu_shift_seq.sv - multi-cycle shift/rotate sequencer applying at most MAX_STEP bits per clock
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int MAX_STEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] r
);

    localparam int               STEP_W   = $clog2(MAX_STEP) + 1;
    localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(MAX_STEP);

    state_e            r_state;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_work;
    logic [CNT_W-1:0]  r_rem;
    logic              r_fill;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_r;

    logic [CNT_W-1:0]  w_m;
    logic [STEP_W-1:0] w_amt;
    logic [DATA_W-1:0] w_shifted;

    // Rotates wrap modulo 32; shifts saturate at 32 so large counts fully clear or sign-fill.
    always_comb begin
        w_m = {1'b0, b[4:0]};
        if (op != OP_ROL && op != OP_ROR && (|b[DATA_W-1:5]))
            w_m = 6'd32;
    end

    assign w_amt = STEP_W'((r_rem > STEP_MAX) ? STEP_MAX : r_rem);

    shift_step #(
        .MAX_STEP (MAX_STEP)
    ) u_step (
        .i_op    (r_op),
        .i_value (r_work),
        .i_amt   (w_amt),
        .i_fill  (r_fill),
        .o_value (w_shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_work  <= '0;
            r_rem   <= '0;
            r_fill  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_r     <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_work <= a;
                        r_rem  <= w_m;
                        r_fill <= (op == OP_SHRA) & a[DATA_W-1];
                        r_busy <= 1'b1;
                        if (!is_legal_op(op) || w_m == '0) begin
                            r_r     <= a;
                            r_err   <= !is_legal_op(op);
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_work <= w_shifted;
                    r_rem  <= r_rem - CNT_W'(w_amt);
                    if (r_rem <= STEP_MAX) begin
                        r_r     <= w_shifted;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign r    = r_r;

endmodule
